mult_div_unit: RTL

//  Multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_arith.sv | 28 ++
 rtl/mult_div_unit.sv | 57 +++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, counter width and long-op classifier shared by the MDU and its bench.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU as accumulating multiplies).
package mdu_pkg;
   localparam logic [3:0] NOP   = 4'd0;
   localparam logic [3:0] MULT  = 4'd1;
   localparam logic [3:0] MULTU = 4'd2;
   localparam logic [3:0] DIV   = 4'd3;
   localparam logic [3:0] DIVU  = 4'd4;
   localparam logic [3:0] MTHI  = 4'd5;
   localparam logic [3:0] MTLO  = 4'd6;
   localparam logic [3:0] MADD  = 4'd7;
   localparam logic [3:0] MADDU = 4'd8;
   localparam logic [3:0] MSUB  = 4'd9;
   localparam logic [3:0] MSUBU = 4'd10;
   localparam int CNT_W = 8;
   // Ops that occupy the unit for a multi-cycle busy period.
   function automatic logic is_long_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
`else
      return op inside {MULT, MULTU, DIV, DIVU};
`endif
   endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit product / {remainder,quotient} for the MDU.
// Ports: op (mdu_pkg code), a/b (32-bit operands) -> result ({hi,lo} image), div0 (divide op with b==0).
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div0
);
   logic               bz;
   logic [31:0]        bd;
   logic signed [32:0] sa, sb;
   always_comb begin
      bz   = b == '0;
      div0 = bz && (op == DIV || op == DIVU);
      // Divisor forced to 1 on zero so the dividers never see 0; the result is discarded anyway.
      bd   = bz ? 32'd1 : b;
      // 33-bit signed operands keep 0x8000_0000 / -1 representable before truncation.
      sa   = {a[31], a};
      sb   = {bd[31], bd};
      result = (op == MULTU || op == MADDU || op == MSUBU) ? {32'b0, a} * {32'b0, b} :
               (op == DIV)  ? {32'(sa % sb), 32'(sa / sb)} :
               (op == DIVU) ? {a % bd, a / bd} :
                              {{32{a[31]}}, a} * {{32{b[31]}}, b};
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Ports: clk, reset (async, active-high), req/op/a/b request, busy, hi_out/lo_out (combinational HI/LO).
// Optional feature macro: MDU_MADD_EN (accumulating MADD/MADDU/MSUB/MSUBU; otherwise those codes are NOPs).
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi, lo;
   logic [63:0]      pend, res, commit_val;
   logic             p_acc, p_sub, p_skip, div0;

   mdu_arith u_arith (.op(op), .a(a), .b(b), .result(res), .div0(div0));

   assign busy   = cnt != '0;
   assign hi_out = hi;
   assign lo_out = lo;
   // Accumulating ops read HI/LO at the commit edge, not at acceptance.
   assign commit_val = p_sub ? {hi, lo} - pend : p_acc ? {hi, lo} + pend : pend;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         pend   <= '0;
         p_acc  <= 1'b0;
         p_sub  <= 1'b0;
         p_skip <= 1'b0;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1) && !p_skip) {hi, lo} <= commit_val;
      end else if (req) begin
         if (op == MTHI) hi <= a;
         if (op == MTLO) lo <= a;
         if (is_long_op(op)) begin
            cnt    <= (op == DIV || op == DIVU) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend   <= res;
            p_skip <= div0;
            p_acc  <= op inside {MADD, MADDU, MSUB, MSUBU};
            p_sub  <= op inside {MSUB, MSUBU};
         end
      end
   end
endmodule
